// File: rtl/VX_fpu_pkg.sv
// ---------------------------------------------------------------------------
// VX_fpu_pkg
//   Shared definitions for the per-warp FPU CSR file:
//     - CSR addresses of fflags, frm and fcsr
//     - CSR-instruction operation encodings
//     - the 5-bit exception flag type
//     - request FSM state encoding
//     - helper computing the value a CSR instruction writes back
// ---------------------------------------------------------------------------
package VX_fpu_pkg;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2,
        CSR_OP_RO = 2'd3
    } csr_op_e;

    typedef logic [4:0] fflags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

    // New CSR value from the old one; read-only returns the old value
    // unchanged, callers suppress the write for that op anyway.
    function automatic logic [7:0] csr_new_value(
        input csr_op_e    op,
        input logic [7:0] old_val,
        input logic [7:0] wdata
    );
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_val | wdata;
            CSR_OP_RC: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/VX_fpu_pending_ctr.sv
// ---------------------------------------------------------------------------
// VX_fpu_pending_ctr
//   Per-warp count of FPU operations in flight. Each FPU block reports issue
//   and retire events with a blocked warp id; block b owns the global warps
//   w with w % NUM_BLOCKS == b, so at most one issue and one retire can hit a
//   given warp per cycle.
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_issue_valid/wid    per-block issue strobe and blocked warp id
//   i_retire_valid/wid   per-block retire strobe and blocked warp id
//   o_zero               per-warp flag: no operations in flight
// ---------------------------------------------------------------------------
module VX_fpu_pending_ctr #(
    parameter int NUM_WARPS  = 8,
    parameter int NUM_BLOCKS = 2,
    parameter int PEND_DEPTH = 4,
    parameter int BW         = 2,
    parameter int PW         = $clog2(PEND_DEPTH + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_BLOCKS-1:0]        i_issue_valid,
    input  logic [NUM_BLOCKS*BW-1:0]     i_issue_wid,
    input  logic [NUM_BLOCKS-1:0]        i_retire_valid,
    input  logic [NUM_BLOCKS*BW-1:0]     i_retire_wid,
    output logic [NUM_WARPS-1:0]         o_zero
);

    localparam logic [PW-1:0] CNT_MAX = PW'(PEND_DEPTH);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        localparam int            B   = w % NUM_BLOCKS;
        localparam logic [BW-1:0] BLK = BW'(w / NUM_BLOCKS);

        logic          w_inc;
        logic          w_dec;
        logic [PW-1:0] r_count;

        assign w_inc = i_issue_valid[B]  && (i_issue_wid[B*BW +: BW]  == BLK);
        assign w_dec = i_retire_valid[B] && (i_retire_wid[B*BW +: BW] == BLK);

        // Up/down count; simultaneous issue and retire cancel out, and the
        // counter holds at either end instead of wrapping.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_count <= '0;
            end else if (w_inc && !w_dec) begin
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + PW'(1);
                end
            end else if (w_dec && !w_inc) begin
                if (r_count != '0) begin
                    r_count <= r_count - PW'(1);
                end
            end
        end

        // Flag bookkeeping errors from the FPU side: issuing past the queue
        // depth or retiring an operation that was never issued.
        always_ff @(posedge i_clk) begin
            if (!i_reset) begin
                assert (!(w_inc && !w_dec && (r_count == CNT_MAX)))
                    else $error("pending counter overflow on warp %0d", w);
                assert (!(w_dec && !w_inc && (r_count == '0)))
                    else $error("pending counter underflow on warp %0d", w);
            end
        end

        assign o_zero[w] = (r_count == '0);
    end

endmodule

// File: rtl/vx_fpu_csr_file.sv
// ---------------------------------------------------------------------------
// vx_fpu_csr_file
//   Per-warp floating-point CSR file. Holds frm and fflags for every warp,
//   answers combinational frm lookups from the FPU blocks, OR-accumulates
//   exception flags written back by FPU responses and executes CSR
//   instructions on fflags (0x001), frm (0x002) and fcsr (0x003). Accesses
//   touching fflags wait until the warp has no FPU operation in flight and
//   no retire/write-back targets it in the same cycle.
//
// Ports
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_fpu_read_wid / o_fpu_read_frm per-block frm lookup (blocked warp id)
//   i_fpu_write_enable/wid/fflags  per-block fflags write-back
//   i_fpu_issue_valid/wid          per-block FPU issue (pending +1)
//   i_fpu_retire_valid/wid         per-block FPU retire (pending -1)
//   i_csr_req_* / o_csr_req_ready  CSR instruction request
//   o_csr_rsp_* / i_csr_rsp_ready  CSR response carrying the old value
// ---------------------------------------------------------------------------
module vx_fpu_csr_file
    import VX_fpu_pkg::*;
#(
    parameter int NUM_WARPS  = 8,
    parameter int NUM_BLOCKS = 2,
    parameter int PEND_DEPTH = 4,
    parameter int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int BW         = ((NUM_WARPS / NUM_BLOCKS) > 1) ?
                               $clog2(NUM_WARPS / NUM_BLOCKS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,

    input  logic [NUM_BLOCKS*BW-1:0]     i_fpu_read_wid,
    output logic [NUM_BLOCKS*3-1:0]      o_fpu_read_frm,

    input  logic [NUM_BLOCKS-1:0]        i_fpu_write_enable,
    input  logic [NUM_BLOCKS*BW-1:0]     i_fpu_write_wid,
    input  logic [NUM_BLOCKS*5-1:0]      i_fpu_write_fflags,

    input  logic [NUM_BLOCKS-1:0]        i_fpu_issue_valid,
    input  logic [NUM_BLOCKS*BW-1:0]     i_fpu_issue_wid,
    input  logic [NUM_BLOCKS-1:0]        i_fpu_retire_valid,
    input  logic [NUM_BLOCKS*BW-1:0]     i_fpu_retire_wid,

    input  logic                         i_csr_req_valid,
    output logic                         o_csr_req_ready,
    input  logic [NW_WIDTH-1:0]          i_csr_req_wid,
    input  logic [11:0]                  i_csr_req_addr,
    input  logic [1:0]                   i_csr_req_op,
    input  logic [7:0]                   i_csr_req_wdata,

    output logic                         o_csr_rsp_valid,
    input  logic                         i_csr_rsp_ready,
    output logic [7:0]                   o_csr_rsp_rdata
);

    localparam int PW = $clog2(PEND_DEPTH + 1);

    logic [2:0]          r_frm    [NUM_WARPS];
    fflags_t             r_fflags [NUM_WARPS];

    csr_state_e          r_state;
    csr_state_e          w_state_next;

    logic [NW_WIDTH-1:0] r_wid;
    logic [11:0]         r_addr;
    csr_op_e             r_op;
    logic [7:0]          r_wdata;
    logic [7:0]          r_rdata;

    logic [NUM_WARPS-1:0] w_zero;
    logic [NUM_WARPS-1:0] w_busy;
    fflags_t              w_wr_flags [NUM_WARPS];

    logic                w_exec;
    logic                w_known;
    logic                w_blocked;
    logic [7:0]          w_old;
    logic [7:0]          w_new;
    logic                w_wen;
    logic                w_wr_fflags;
    logic                w_wr_frm;
    logic [2:0]          w_new_frm;

    VX_fpu_pending_ctr #(
        .NUM_WARPS  (NUM_WARPS),
        .NUM_BLOCKS (NUM_BLOCKS),
        .PEND_DEPTH (PEND_DEPTH),
        .BW         (BW),
        .PW         (PW)
    ) u_pending (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_issue_valid  (i_fpu_issue_valid),
        .i_issue_wid    (i_fpu_issue_wid),
        .i_retire_valid (i_fpu_retire_valid),
        .i_retire_wid   (i_fpu_retire_wid),
        .o_zero         (w_zero)
    );

    // frm lookup per block: the blocked id plus the block index give the
    // global warp, so the blocks never see each other's warps.
    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_read
        logic [NW_WIDTH-1:0] w_rd_gid;
        assign w_rd_gid = NW_WIDTH'(i_fpu_read_wid[b*BW +: BW]) * NW_WIDTH'(NUM_BLOCKS)
                        + NW_WIDTH'(b);
        assign o_fpu_read_frm[b*3 +: 3] = r_frm[w_rd_gid];
    end

    // Per-warp view of this cycle's write-back and retire traffic. A warp is
    // busy for fflags access while anything is in flight or landing now.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        localparam int            B   = w % NUM_BLOCKS;
        localparam logic [BW-1:0] BLK = BW'(w / NUM_BLOCKS);

        logic w_write_hit;
        logic w_retire_hit;

        assign w_write_hit  = i_fpu_write_enable[B] && (i_fpu_write_wid[B*BW +: BW] == BLK);
        assign w_retire_hit = i_fpu_retire_valid[B] && (i_fpu_retire_wid[B*BW +: BW] == BLK);
        assign w_wr_flags[w] = w_write_hit ? i_fpu_write_fflags[B*5 +: 5] : '0;
        assign w_busy[w]     = !w_zero[w] || w_write_hit || w_retire_hit;
    end

    // Old value of the addressed CSR for the latched request; unknown
    // addresses read as zero and are never written.
    always_comb begin
        w_known = 1'b1;
        w_old   = '0;
        case (r_addr)
            CSR_FFLAGS: w_old = {3'b000, r_fflags[r_wid]};
            CSR_FRM:    w_old = {5'b00000, r_frm[r_wid]};
            CSR_FCSR:   w_old = {r_frm[r_wid], r_fflags[r_wid]};
            default:    w_known = 1'b0;
        endcase
    end

    assign w_blocked   = ((r_addr == CSR_FFLAGS) || (r_addr == CSR_FCSR)) && w_busy[r_wid];
    assign w_new       = csr_new_value(r_op, w_old, r_wdata);
    assign w_wen       = w_exec && w_known && (r_op != CSR_OP_RO);
    assign w_wr_fflags = w_wen && ((r_addr == CSR_FFLAGS) || (r_addr == CSR_FCSR));
    assign w_wr_frm    = w_wen && ((r_addr == CSR_FRM) || (r_addr == CSR_FCSR));
    assign w_new_frm   = (r_addr == CSR_FCSR) ? w_new[7:5] : w_new[2:0];

    // Request FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request FSM next state and handshake outputs.
    always_comb begin
        w_state_next    = r_state;
        o_csr_req_ready = 1'b0;
        o_csr_rsp_valid = 1'b0;
        w_exec          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_csr_req_ready = 1'b1;
                if (i_csr_req_valid) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_blocked) begin
                    w_exec       = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                o_csr_rsp_valid = 1'b1;
                if (i_csr_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latch and response data; rdata is captured at execute and
    // held until the response is accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wid   <= '0;
            r_addr  <= '0;
            r_op    <= CSR_OP_RW;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == ST_IDLE) && i_csr_req_valid) begin
                r_wid   <= i_csr_req_wid;
                r_addr  <= i_csr_req_addr;
                r_op    <= csr_op_e'(i_csr_req_op);
                r_wdata <= i_csr_req_wdata;
            end
            if (w_exec) begin
                r_rdata <= w_old;
            end
        end
    end

    assign o_csr_rsp_rdata = r_rdata;

    // Per-warp CSR state. The CSR write and an FPU flag write-back never hit
    // the same warp in one cycle, so giving the CSR write priority loses
    // nothing.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_frm[i]    <= '0;
                r_fflags[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (w_wr_fflags && (r_wid == NW_WIDTH'(i))) begin
                    r_fflags[i] <= w_new[4:0];
                end else begin
                    r_fflags[i] <= r_fflags[i] | w_wr_flags[i];
                end
                if (w_wr_frm && (r_wid == NW_WIDTH'(i))) begin
                    r_frm[i] <= w_new_frm;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_fpu_csr_file.sv
// ---------------------------------------------------------------------------
// tb_vx_fpu_csr_file
//   Directed and randomized checks of the FPU CSR file against a reference
//   model holding per-warp frm, fflags and in-flight counts.
// ---------------------------------------------------------------------------
module tb_vx_fpu_csr_file;

    localparam int NW  = 8;
    localparam int NB  = 2;
    localparam int PD  = 4;
    localparam int BW  = 2;
    localparam int NWW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NB*BW-1:0] fpuReadWid = '0;
    logic [NB*3-1:0]  fpuReadFrm;
    logic [NB-1:0]    fpuWriteEnable = '0;
    logic [NB*BW-1:0] fpuWriteWid = '0;
    logic [NB*5-1:0]  fpuWriteFflags = '0;
    logic [NB-1:0]    fpuIssueValid = '0;
    logic [NB*BW-1:0] fpuIssueWid = '0;
    logic [NB-1:0]    fpuRetireValid = '0;
    logic [NB*BW-1:0] fpuRetireWid = '0;
    logic             csrReqValid = 1'b0;
    logic             csrReqReady;
    logic [NWW-1:0]   csrReqWid = '0;
    logic [11:0]      csrReqAddr = '0;
    logic [1:0]       csrReqOp = '0;
    logic [7:0]       csrReqWdata = '0;
    logic             csrRspValid;
    logic             csrRspReady = 1'b0;
    logic [7:0]       csrRspRdata;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] mFrm   [NW];
    logic [4:0] mFlags [NW];
    int         mPend  [NW];

    int         reqWid;
    int         reqAddr;
    int         reqOp;
    logic [7:0] reqWdata;

    int         addrTable [6] = '{1, 2, 3, 0, 'h7FF, 4};

    vx_fpu_csr_file #(
        .NUM_WARPS  (NW),
        .NUM_BLOCKS (NB),
        .PEND_DEPTH (PD)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_fpu_read_wid     (fpuReadWid),
        .o_fpu_read_frm     (fpuReadFrm),
        .i_fpu_write_enable (fpuWriteEnable),
        .i_fpu_write_wid    (fpuWriteWid),
        .i_fpu_write_fflags (fpuWriteFflags),
        .i_fpu_issue_valid  (fpuIssueValid),
        .i_fpu_issue_wid    (fpuIssueWid),
        .i_fpu_retire_valid (fpuRetireValid),
        .i_fpu_retire_wid   (fpuRetireWid),
        .i_csr_req_valid    (csrReqValid),
        .o_csr_req_ready    (csrReqReady),
        .i_csr_req_wid      (csrReqWid),
        .i_csr_req_addr     (csrReqAddr),
        .i_csr_req_op       (csrReqOp),
        .i_csr_req_wdata    (csrReqWdata),
        .o_csr_rsp_valid    (csrRspValid),
        .i_csr_rsp_ready    (csrRspReady),
        .o_csr_rsp_rdata    (csrRspRdata)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // One comparison: counted, and reported when it misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NW; i++) begin
            mFrm[i]   = '0;
            mFlags[i] = '0;
            mPend[i]  = 0;
        end
    endtask

    // Old CSR value according to the architectural rules.
    function automatic logic [7:0] modelOld(input int w, input int a);
        case (a)
            1:       return {3'b000, mFlags[w]};
            2:       return {5'b00000, mFrm[w]};
            3:       return {mFrm[w], mFlags[w]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelApply(input int w, input int a, input int op, input logic [7:0] wd);
        logic [7:0] oldV;
        logic [7:0] newV;
        oldV = modelOld(w, a);
        if (a < 1 || a > 3 || op == 3) return;
        if (op == 0)      newV = wd;
        else if (op == 1) newV = oldV | wd;
        else              newV = oldV & ~wd;
        if (a == 1) mFlags[w] = newV[4:0];
        if (a == 2) mFrm[w]   = newV[2:0];
        if (a == 3) begin
            mFrm[w]   = newV[7:5];
            mFlags[w] = newV[4:0];
        end
    endtask

    // One FPU cycle: optional issue, retire (with its flag write-back) and
    // write-only flag update, each to a global warp (-1 = none).
    task automatic applyStimulus(input int iw, input int rw, input int ww, input logic [4:0] fl);
        if (iw >= 0) begin
            fpuIssueValid[iw % NB] = 1'b1;
            fpuIssueWid[(iw % NB)*BW +: BW] = BW'(iw / NB);
        end
        if (rw >= 0) begin
            fpuRetireValid[rw % NB] = 1'b1;
            fpuRetireWid[(rw % NB)*BW +: BW] = BW'(rw / NB);
            fpuWriteEnable[rw % NB] = 1'b1;
            fpuWriteWid[(rw % NB)*BW +: BW] = BW'(rw / NB);
            fpuWriteFflags[(rw % NB)*5 +: 5] = fl;
        end
        if (ww >= 0) begin
            fpuWriteEnable[ww % NB] = 1'b1;
            fpuWriteWid[(ww % NB)*BW +: BW] = BW'(ww / NB);
            fpuWriteFflags[(ww % NB)*5 +: 5] = fl;
        end
        step();
        if (iw >= 0) mPend[iw]++;
        if (rw >= 0) begin
            mPend[rw]--;
            mFlags[rw] = mFlags[rw] | fl;
        end
        if (ww >= 0) mFlags[ww] = mFlags[ww] | fl;
        fpuIssueValid  = '0;
        fpuRetireValid = '0;
        fpuWriteEnable = '0;
        fpuWriteFflags = '0;
    endtask

    task automatic checkFrmAll(input string tag);
        for (int blk = 0; blk < NW / NB; blk++) begin
            for (int b = 0; b < NB; b++) fpuReadWid[b*BW +: BW] = BW'(blk);
            #1;
            for (int b = 0; b < NB; b++)
                checkOutput(tag, {29'd0, fpuReadFrm[b*3 +: 3]}, {29'd0, mFrm[blk*NB + b]});
        end
    endtask

    task automatic sendCsrReq(input int w, input int a, input int op, input logic [7:0] wd);
        checkOutput("req_ready_idle", {31'd0, csrReqReady}, 32'd1);
        csrReqValid = 1'b1;
        csrReqWid   = NWW'(w);
        csrReqAddr  = 12'(a);
        csrReqOp    = 2'(op);
        csrReqWdata = wd;
        reqWid = w; reqAddr = a; reqOp = op; reqWdata = wd;
        step();
        csrReqValid = 1'b0;
        checkOutput("req_ready_busy", {31'd0, csrReqReady}, 32'd0);
    endtask

    // Wait (bounded) for the response, check latency from the last edge and
    // rdata, hold it for 'hold' cycles, then accept it.
    task automatic finishCsrReq(input string tag, input int hold);
        int cycles;
        logic [7:0] expData;
        cycles = 0;
        while (csrRspValid !== 1'b1 && cycles < 50) begin
            step();
            cycles++;
        end
        if (csrRspValid !== 1'b1) begin
            checkOutput({tag, "_rsp_valid"}, {31'd0, csrRspValid}, 32'd1);
            return;
        end
        checkOutput({tag, "_latency"}, cycles, 32'd1);
        expData = modelOld(reqWid, reqAddr);
        modelApply(reqWid, reqAddr, reqOp, reqWdata);
        checkOutput({tag, "_rdata"}, {24'd0, csrRspRdata}, {24'd0, expData});
        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput({tag, "_hold_rdata"}, {24'd0, csrRspRdata}, {24'd0, expData});
            checkOutput({tag, "_hold_req_ready"}, {31'd0, csrReqReady}, 32'd0);
            checkOutput({tag, "_hold_valid"}, {31'd0, csrRspValid}, 32'd1);
        end
        csrRspReady = 1'b1;
        step();
        csrRspReady = 1'b0;
        checkOutput({tag, "_rsp_done"}, {31'd0, csrRspValid}, 32'd0);
    endtask

    initial begin
        int w;
        int w2;
        modelReset();
        #12 reset = 1'b0;
        step();

        // Reset state.
        checkOutput("reset_req_ready", {31'd0, csrReqReady}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, csrRspValid}, 32'd0);
        checkOutput("reset_rsp_rdata", {24'd0, csrRspRdata}, 32'd0);
        checkFrmAll("reset_read_frm");

        // frm write on warp 0 becomes visible to block 0 afterwards.
        sendCsrReq(0, 2, 0, 8'h03);
        finishCsrReq("frm_rw", 0);
        checkFrmAll("frm_after_rw");

        // Write-backs to warp 5 (block 1, blocked id 2) accumulate.
        applyStimulus(-1, -1, 5, 5'h01);
        applyStimulus(-1, -1, 5, 5'h04);
        sendCsrReq(5, 1, 3, 8'h00);
        finishCsrReq("fflags_acc", 0);

        // Three ops in flight on warp 4: frm is free, fflags must wait.
        applyStimulus(4, -1, -1, 5'h00);
        applyStimulus(4, -1, -1, 5'h00);
        applyStimulus(4, -1, -1, 5'h00);
        sendCsrReq(4, 2, 3, 8'h00);
        finishCsrReq("frm_unblocked", 0);
        sendCsrReq(4, 1, 3, 8'h00);
        step();
        checkOutput("blocked_idle", {31'd0, csrRspValid}, 32'd0);
        applyStimulus(-1, 4, -1, 5'h02);
        checkOutput("blocked_retire1", {31'd0, csrRspValid}, 32'd0);
        applyStimulus(-1, 4, -1, 5'h08);
        checkOutput("blocked_retire2", {31'd0, csrRspValid}, 32'd0);
        applyStimulus(-1, 4, -1, 5'h10);
        checkOutput("blocked_retire3", {31'd0, csrRspValid}, 32'd0);
        finishCsrReq("fflags_drained", 0);

        // fcsr set then cleared; response held for five cycles.
        sendCsrReq(6, 3, 0, 8'hE7);
        finishCsrReq("fcsr_rw", 0);
        sendCsrReq(6, 3, 2, 8'h21);
        finishCsrReq("fcsr_rc", 5);
        sendCsrReq(6, 3, 3, 8'h00);
        finishCsrReq("fcsr_read", 0);
        checkFrmAll("frm_after_fcsr");

        // Same-cycle issue and retire keep warp 3 pending.
        applyStimulus(3, -1, -1, 5'h00);
        applyStimulus(3, 3, -1, 5'h02);
        sendCsrReq(3, 3, 1, 8'h40);
        step();
        checkOutput("same_cycle_still_pending", {31'd0, csrRspValid}, 32'd0);
        applyStimulus(-1, 3, -1, 5'h08);
        checkOutput("same_cycle_last_retire", {31'd0, csrRspValid}, 32'd0);
        finishCsrReq("same_cycle_fcsr", 0);

        // Randomized FPU traffic followed by randomized CSR instructions.
        for (int i = 0; i < 16; i++) begin
            w  = $urandom_range(0, NW - 1);
            w2 = (w + 1 + 2 * $urandom_range(0, NW / 2 - 1)) % NW;
            applyStimulus(w, -1, -1, 5'h00);
            applyStimulus(-1, w, -1, 5'($urandom_range(0, 31)));
            applyStimulus(-1, -1, w2, 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 24; i++) begin
            sendCsrReq($urandom_range(0, NW - 1), addrTable[$urandom_range(0, 5)],
                       $urandom_range(0, 3), 8'($urandom_range(0, 255)));
            finishCsrReq("rand_csr", 0);
        end
        for (int i = 0; i < NW; i++) begin
            sendCsrReq(i, 3, 3, 8'h00);
            finishCsrReq("rand_fcsr_readback", 0);
        end
        checkFrmAll("rand_read_frm");

        // Reset while a blocked request sits in WAIT.
        sendCsrReq(7, 2, 0, 8'h05);
        finishCsrReq("frm_before_reset", 0);
        applyStimulus(4, -1, -1, 5'h00);
        sendCsrReq(4, 1, 0, 8'h1F);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_req_ready", {31'd0, csrReqReady}, 32'd1);
        checkOutput("midreset_rsp_valid", {31'd0, csrRspValid}, 32'd0);
        checkOutput("midreset_rsp_rdata", {24'd0, csrRspRdata}, 32'd0);
        #1 reset = 1'b0;
        modelReset();
        step();
        checkFrmAll("after_reset_read_frm");
        sendCsrReq(4, 3, 3, 8'h00);
        finishCsrReq("after_reset_fcsr", 0);
        sendCsrReq(5, 1, 3, 8'h00);
        finishCsrReq("after_reset_fflags", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vx_fpu_csr_file.md
# VX_fpu_csr_file

Per-warp floating-point CSR file: the responder end of the FPU CSR interface driven by each FPU block. It holds `frm` and `fflags` for every warp and serves dynamic-rounding-mode reads to the FPU blocks. It OR-accumulates exception flags written back by FPU responses, and executes CSR-instruction accesses to fflags/frm/fcsr. Accesses that touch fflags are held until that warp's in-flight FPU operations have drained.

## Interface
- NUM_WARPS, `NUM_WARPS: total warps.
- NUM_BLOCKS, `NUM_FPU_BLOCKS: FPU blocks. Block b serves global warps w with w % NUM_BLOCKS == b.
- PEND_DEPTH, `FPUQ_SIZE: maximum outstanding FPU ops per block. The counter width is PW = $clog2(PEND_DEPTH+1).
- Derived constants: NW_WIDTH = `LOG2UP(NUM_WARPS); BW = `LOG2UP(NUM_WARPS/NUM_BLOCKS) (blocked warp id).
- clk  in  1  clock. One clock domain only.
- reset  in  1  reset. Asynchronous, active-high.
- fpu_read_wid  in  [NUM_BLOCKS][BW]  blocked warp id for the frm lookup.
- fpu_read_frm  out  [NUM_BLOCKS][3]  frm of that warp, combinational.
- fpu_write_enable  in  [NUM_BLOCKS]  fflags write-back strobe.
- fpu_write_wid  in  [NUM_BLOCKS][BW]  blocked warp id for the write-back.
- fpu_write_fflags  in  [NUM_BLOCKS][5]  flags to OR into the warp's fflags.
- fpu_issue_valid / fpu_issue_wid  in  [NUM_BLOCKS] / [NUM_BLOCKS][BW]  an FPU request fired. Increments pending.
- fpu_retire_valid / fpu_retire_wid  in  [NUM_BLOCKS] / [NUM_BLOCKS][BW]  an FPU eop response retired. Decrements pending. Cycle-aligned with fpu_write_*.
- csr_req_valid / csr_req_ready  in / out  1  CSR instruction request handshake.
- csr_req_wid  in  NW_WIDTH  global warp id.
- csr_req_addr  in  12  CSR address.
- csr_req_op  in  2  CSR operation: 0 = RW, 1 = RS, 2 = RC, 3 = read-only.
- csr_req_wdata  in  8  operand, right-aligned.
- csr_rsp_valid / csr_rsp_ready  out / in  1  response handshake.
- csr_rsp_rdata  out  8  old CSR value, zero-extended.

## Operation
- Warp mapping: global wid = blocked_wid * NUM_BLOCKS + b. Blocks never alias warps.
- Flag write-back: when fpu_write_enable[b] is high, `fflags[w] <= fflags[w] | fpu_write_fflags[b]`.
- Pending counters: pending[w] (PW bits) counts up on issue and down on retire.
  - Issue and retire to the same warp in one cycle leave the count unchanged.
  - Overflow (count already at PEND_DEPTH) and underflow (count at 0) are assertion errors. The counter saturates.
- CSR addresses: 0x001 fflags = fflags[4:0]; 0x002 frm = frm[2:0]; 0x003 fcsr = {frm,fflags}[7:0].
  - Any other address: rdata = 0, no state change.
- Write value computed from the old value (old = the selected CSR's current value):
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Op 3: no write.
  - Writes are truncated to the field width. frm values 5–7 are stored as given.
- FSM states IDLE, WAIT, RESP. Reset state is IDLE.
  - IDLE: csr_req_ready = 1. On fire, latch the request and go to WAIT.
  - WAIT: the request executes when it is not blocked, then the FSM goes to RESP. Execution captures rdata and performs the write at that edge.
    - An fflags or fcsr access is blocked while pending[wid] != 0 or while fpu_retire or fpu_write targets that wid this cycle.
    - A frm-only access or an unknown address is never blocked.
  - RESP: csr_rsp_valid = 1. On csr_rsp_ready, return to IDLE. csr_req_ready is 0 in WAIT and RESP.
- Same-cycle CSR execute and FPU fflags write to one warp cannot occur, because the blocking rule above excludes it.
- An issue to the same wid in the execute cycle is a younger op: execute proceeds and pending increments.

## Timing
- Reset values: fflags 0, frm 0 (RNE), pending 0, csr_req_ready 1, csr_rsp_valid 0, csr_rsp_rdata 0. fpu_read_frm therefore reads 0.
- fpu_read_frm is combinational. A frm write becomes visible the cycle after the execute edge.
- Unblocked CSR latency:
  - The request fires in cycle N.
  - Execute happens at the end of cycle N+1.
  - rsp_valid is high from cycle N+2 and holds, with stable rdata, until accepted.
- Blocked CSR: execute happens at the end of the first WAIT cycle in which pending[wid]==0 and no retire or write targets that wid.
- Reset asserted mid-transaction drops the request and returns all state to the reset values immediately (asynchronous).

## Structure
- Shared package (VX_fpu_pkg): CSR address constants FFLAGS/FRM/FCSR, csr_op encodings, and fflags_t (5 b).
- One sub-module, VX_fpu_pending_ctr: a per-warp up/down counter array with a zero flag per warp and overflow/underflow assertions.

## Test plan
- Reset, then block 0 with read_wid=0: read_frm=0. Then CSR RW 0x002 wdata=3 on wid 0: rsp rdata=0. Next cycle, read_frm[0]=3.
- fpu_write_enable block 1, wid_blk 2, fflags 0x01, then 0x04, with NUM_BLOCKS=2: CSR read 0x001 on wid 5 returns 0x05.
- Issue 3 ops on wid 4, then send a CSR read of fflags. The response must stay low until the 3rd retire. rdata must include the flags of all 3 writes.
- With pending on wid 4, a frm read of wid 4 completes in 2 cycles, unblocked.
- fcsr=0xE7 followed by RC 0x003 wdata=0x21: rdata=0xE7, and fcsr then reads 0xC6. Holding rsp_ready=0 for 5 cycles keeps rdata stable with req_ready=0.
- Issue and retire to the same wid in one cycle leave pending unchanged. Asserting reset during WAIT clears rsp_valid, and req_ready=1 immediately.
